// File: rtl/alarm_controller_pkg.sv
// rtl/alarm_controller_pkg.sv - shared types and constants for the anti-theft alarm controller
package alarm_controller_pkg;

    localparam int TW_DEF = 4;

    typedef enum logic [2:0] {
        ARMED       = 3'd0,
        TRIGGERED   = 3'd1,
        SOUND_ALARM = 3'd2,
        DISARMED    = 3'd3,
        IGN_OFF     = 3'd4,
        DOOR_OPEN   = 3'd5,
        ARMING      = 3'd6
    } state_e;

    localparam logic [1:0] P_ARM       = 2'd0;
    localparam logic [1:0] P_DRIVER    = 2'd1;
    localparam logic [1:0] P_PASSENGER = 2'd2;
    localparam logic [1:0] P_ALARM     = 2'd3;

endpackage

// File: rtl/alarm_controller_countdown_timer.sv
// rtl/alarm_controller_countdown_timer.sv - loadable seconds down-counter that saturates at zero
module countdown_timer
    import alarm_controller_pkg::*;
#(
    parameter int TW = TW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_value,
    input  logic          tick,
    output logic          expired
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // A load absorbs a coincident tick, so a load of V expires after exactly V ticks.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - anti-theft state machine with reprogrammable entry/arm/alarm time table
module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int TW                    = TW_DEF,
    parameter int T_ARM_DELAY_DEF       = 6,
    parameter int T_DRIVER_DELAY_DEF    = 8,
    parameter int T_PASSENGER_DELAY_DEF = 15,
    parameter int T_ALARM_ON_DEF        = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          one_hz_enable,
    input  logic          two_hz_enable,
    input  logic          ignition,
    input  logic          door_driver,
    input  logic          door_passenger,
    input  logic          reprogram,
    input  logic [1:0]    time_param_sel,
    input  logic [TW-1:0] time_value,
    output logic          enable_siren,
    output logic          status_indicator,
    output logic          armed
);

    state_e        state_q;
    state_e        state_d;
    logic          status_q;
    logic          status_d;
    logic [TW-1:0] table_q [4];
    logic [TW-1:0] table_d [4];
    logic          load;
    logic [TW-1:0] load_value;
    logic          expired;

    countdown_timer #(.TW(TW)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .tick       (one_hz_enable),
        .expired    (expired)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            table_d[i] = table_q[i];
        end
        if (reprogram) begin
            table_d[time_param_sel] = time_value;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q            <= ARMED;
            status_q           <= 1'b0;
            table_q[P_ARM]       <= TW'(T_ARM_DELAY_DEF);
            table_q[P_DRIVER]    <= TW'(T_DRIVER_DELAY_DEF);
            table_q[P_PASSENGER] <= TW'(T_PASSENGER_DELAY_DEF);
            table_q[P_ALARM]     <= TW'(T_ALARM_ON_DEF);
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            for (int i = 0; i < 4; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    // Loads read table_q, so a reprogram in the same cycle only affects later loads.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_value = '0;
        if (reprogram) begin
            state_d = ARMED;
            load    = 1'b1;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (door_driver) begin
                        state_d    = TRIGGERED;
                        load       = 1'b1;
                        load_value = table_q[P_DRIVER];
                    end else if (door_passenger) begin
                        state_d    = TRIGGERED;
                        load       = 1'b1;
                        load_value = table_q[P_PASSENGER];
                    end
                end
                TRIGGERED: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (expired) begin
                        state_d    = SOUND_ALARM;
                        load       = 1'b1;
                        load_value = table_q[P_ALARM];
                    end
                end
                SOUND_ALARM: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (door_driver || door_passenger) begin
                        load       = 1'b1;
                        load_value = table_q[P_ALARM];
                    end else if (expired) begin
                        state_d = ARMED;
                    end
                end
                DISARMED: begin
                    if (!ignition) begin
                        state_d = IGN_OFF;
                    end
                end
                IGN_OFF: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (door_driver) begin
                        state_d = DOOR_OPEN;
                    end
                end
                DOOR_OPEN: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (!door_driver) begin
                        state_d    = ARMING;
                        load       = 1'b1;
                        load_value = table_q[P_ARM];
                    end
                end
                ARMING: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (door_driver || door_passenger) begin
                        load       = 1'b1;
                        load_value = table_q[P_ARM];
                    end else if (expired) begin
                        state_d = ARMED;
                    end
                end
                default: begin
                    state_d = ARMED;
                end
            endcase
        end
    end

    // The LED blink phase restarts from dark on every entry into ARMED, including a reprogram.
    always_comb begin
        status_d = 1'b0;
        unique case (state_d)
            ARMED: begin
                if (reprogram || (state_q != ARMED)) begin
                    status_d = 1'b0;
                end else if (two_hz_enable) begin
                    status_d = ~status_q;
                end else begin
                    status_d = status_q;
                end
            end
            TRIGGERED, SOUND_ALARM: status_d = 1'b1;
            default:                status_d = 1'b0;
        endcase
        enable_siren     = (state_q == SOUND_ALARM);
        armed            = (state_q == ARMED);
        status_indicator = status_q;
    end

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed self-checking bench for alarm_controller
module tb_alarm_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       one_hz_enable = 1'b0;
    logic       two_hz_enable = 1'b0;
    logic       ignition = 1'b0;
    logic       door_driver = 1'b0;
    logic       door_passenger = 1'b0;
    logic       reprogram = 1'b0;
    logic [1:0] time_param_sel = 2'd0;
    logic [3:0] time_value = 4'd0;
    logic       enable_siren;
    logic       status_indicator;
    logic       armed;

    int checks = 0;
    int failures = 0;

    alarm_controller dut (
        .clock            (clock),
        .reset            (reset),
        .one_hz_enable    (one_hz_enable),
        .two_hz_enable    (two_hz_enable),
        .ignition         (ignition),
        .door_driver      (door_driver),
        .door_passenger   (door_passenger),
        .reprogram        (reprogram),
        .time_param_sel   (time_param_sel),
        .time_value       (time_value),
        .enable_siren     (enable_siren),
        .status_indicator (status_indicator),
        .armed            (armed)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        one_hz_enable = 1'b1;
        step();
        one_hz_enable = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic siren, input logic stat, input logic arm);
        check({tag, ".siren"}, enable_siren, siren);
        check({tag, ".status"}, status_indicator, stat);
        check({tag, ".armed"}, armed, arm);
    endtask

    initial begin
        #12;
        check_outs("reset", 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        step();
        check_outs("post_reset", 1'b0, 1'b0, 1'b1);

        // Driver door: 8 s entry delay, then 10 s siren.
        door_driver = 1'b1;
        step();
        door_driver = 1'b0;
        check_outs("drv_trig", 1'b0, 1'b1, 1'b0);
        ticks(7);
        check_outs("drv_7", 1'b0, 1'b1, 1'b0);
        tick();
        check_outs("drv_8", 1'b1, 1'b1, 1'b0);
        ticks(9);
        check_outs("alarm_9", 1'b1, 1'b1, 1'b0);
        tick();
        check_outs("alarm_10", 1'b0, 1'b0, 1'b1);

        // Passenger door, then ignition disarms before the siren.
        door_passenger = 1'b1;
        step();
        door_passenger = 1'b0;
        check_outs("pass_trig", 1'b0, 1'b1, 1'b0);
        ticks(3);
        check_outs("pass_3", 1'b0, 1'b1, 1'b0);
        ignition = 1'b1;
        step();
        check_outs("disarm", 1'b0, 1'b0, 1'b0);
        ticks(15);
        check_outs("disarm_hold", 1'b0, 1'b0, 1'b0);

        // Arming path with a passenger door restarting the count.
        ignition = 1'b0;
        step();
        door_driver = 1'b1;
        step();
        door_driver = 1'b0;
        step();
        check_outs("arming", 1'b0, 1'b0, 1'b0);
        ticks(4);
        door_passenger = 1'b1;
        step();
        door_passenger = 1'b0;
        step();
        ticks(5);
        check_outs("arming_5", 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("armed_6", 1'b0, 1'b0, 1'b1);

        // Siren held by an open door, then exactly 10 s after close.
        door_driver = 1'b1;
        step();
        ticks(8);
        check_outs("held_sound", 1'b1, 1'b1, 1'b0);
        ticks(20);
        check_outs("held_20", 1'b1, 1'b1, 1'b0);
        door_driver = 1'b0;
        step();
        ticks(9);
        check_outs("close_9", 1'b1, 1'b1, 1'b0);
        tick();
        check_outs("close_10", 1'b0, 1'b0, 1'b1);

        // Both doors together use the driver delay, then reprogram kills the siren.
        door_driver = 1'b1;
        door_passenger = 1'b1;
        step();
        door_driver = 1'b0;
        door_passenger = 1'b0;
        ticks(7);
        check_outs("both_7", 1'b0, 1'b1, 1'b0);
        tick();
        check_outs("both_8", 1'b1, 1'b1, 1'b0);
        reprogram = 1'b1;
        time_param_sel = 2'd1;
        time_value = 4'd2;
        step();
        reprogram = 1'b0;
        check_outs("reprog_kill", 1'b0, 1'b0, 1'b1);

        // New driver delay of 2 s is in effect.
        door_driver = 1'b1;
        step();
        door_driver = 1'b0;
        tick();
        check_outs("short_1", 1'b0, 1'b1, 1'b0);
        tick();
        check_outs("short_2", 1'b1, 1'b1, 1'b0);
        reprogram = 1'b1;
        time_param_sel = 2'd0;
        time_value = 4'd6;
        step();
        reprogram = 1'b0;
        check_outs("reprog_2", 1'b0, 1'b0, 1'b1);

        // Status LED blinks on each 2 Hz strobe while armed.
        for (int i = 0; i < 4; i++) begin
            step();
            step();
            check("blink_hold", status_indicator, i[0]);
            two_hz_enable = 1'b1;
            step();
            two_hz_enable = 1'b0;
            check("blink_toggle", status_indicator, ~i[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
